// File: rtl/acc_alu_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : acc_alu_seq_if
// Brief  : Sequencer-side control and status bundle for the accumulator ALU.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
interface acc_alu_seq_if #(
    parameter int OP_W = 3
) ();
    logic            ACC_bus;
    logic            load_ACC;
    logic            ALU_ACC;
    logic [OP_W-1:0] alu_op;
    logic            z_flag;
    logic            n_flag;
    logic            c_flag;
    logic            v_flag;
    logic            busy;
    logic            done;

    modport master (
        output ACC_bus, load_ACC, ALU_ACC, alu_op,
        input  z_flag, n_flag, c_flag, v_flag, busy, done
    );

    modport slave (
        input  ACC_bus, load_ACC, ALU_ACC, alu_op,
        output z_flag, n_flag, c_flag, v_flag, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/acc_alu_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : acc_alu_seq
// Brief  : Sysbus accumulator ALU with flags and multi-cycle shift/multiply.
//          Define ALU_MUL_EN to build the sequential multiply for op 7.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module acc_alu_seq #(
    parameter int WORD_W = 8,
    parameter int OP_W   = 3,
    parameter int SH_W   = $clog2(WORD_W)
) (
    input  wire              clock,
    input  wire              n_reset,
    acc_alu_seq_if.slave     bus,
    inout  wire [WORD_W-1:0] sysbus
);
    localparam int              MSB     = WORD_W - 1;
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_INC  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SHR  = OP_W'(6);
`ifdef ALU_MUL_EN
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(7);
`endif
    localparam logic [WORD_W-1:0] C_MAX_POS = {1'b0, {(WORD_W-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN_SHR = 2'd1,
        S_RUN_MUL = 2'd2
    } state_t;

    state_t            r_state,  w_state_nxt;
    logic [WORD_W-1:0] r_acc,    w_acc_nxt;
    logic              r_c,      w_c_nxt;
    logic              r_v,      w_v_nxt;
    logic              r_done,   w_done_nxt;
    logic [SH_W-1:0]   r_cnt,    w_cnt_nxt;
    logic [WORD_W:0]   w_add;
    logic [WORD_W-1:0] w_sub;
    logic [WORD_W-1:0] w_inc;

    assign w_add = {1'b0, r_acc} + {1'b0, sysbus};
    assign w_sub = r_acc - sysbus;
    assign w_inc = r_acc + WORD_W'(1);

`ifdef ALU_MUL_EN
    logic [2*WORD_W-1:0] r_mcand,  w_mcand_nxt;
    logic [2*WORD_W-1:0] r_prod,   w_prod_nxt;
    logic [WORD_W-1:0]   r_mplier, w_mplier_nxt;
    logic [2*WORD_W-1:0] w_prod_sum;

    assign w_prod_sum = r_prod + (r_mplier[0] ? r_mcand : '0);
`endif

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
`ifdef ALU_MUL_EN
            r_mcand  <= '0;
            r_prod   <= '0;
            r_mplier <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_c      <= w_c_nxt;
            r_v      <= w_v_nxt;
            r_done   <= w_done_nxt;
            r_cnt    <= w_cnt_nxt;
`ifdef ALU_MUL_EN
            r_mcand  <= w_mcand_nxt;
            r_prod   <= w_prod_nxt;
            r_mplier <= w_mplier_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_c_nxt      = r_c;
        w_v_nxt      = r_v;
        w_done_nxt   = 1'b0;
        w_cnt_nxt    = r_cnt;
`ifdef ALU_MUL_EN
        w_mcand_nxt  = r_mcand;
        w_prod_nxt   = r_prod;
        w_mplier_nxt = r_mplier;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.load_ACC) begin
                    if (!bus.ALU_ACC) begin
                        w_acc_nxt = sysbus;
                    end else begin
                        case (bus.alu_op)
                            OP_ADD: begin
                                w_acc_nxt = w_add[MSB:0];
                                w_c_nxt   = w_add[WORD_W];
                                w_v_nxt   = (r_acc[MSB] == sysbus[MSB]) && (w_add[MSB] != r_acc[MSB]);
                            end
                            OP_SUB: begin
                                w_acc_nxt = w_sub;
                                w_c_nxt   = (r_acc < sysbus);
                                w_v_nxt   = (r_acc[MSB] != sysbus[MSB]) && (w_sub[MSB] != r_acc[MSB]);
                            end
                            OP_XOR: w_acc_nxt = r_acc ^ sysbus;
                            OP_INC: begin
                                w_acc_nxt = w_inc;
                                w_c_nxt   = &r_acc;
                                w_v_nxt   = (r_acc == C_MAX_POS);
                            end
                            OP_AND: w_acc_nxt = r_acc & sysbus;
                            OP_OR:  w_acc_nxt = r_acc | sysbus;
                            OP_SHR: begin
                                w_cnt_nxt   = sysbus[SH_W-1:0];
                                w_state_nxt = S_RUN_SHR;
                            end
`ifdef ALU_MUL_EN
                            OP_MUL: begin
                                w_mcand_nxt  = {{WORD_W{1'b0}}, r_acc};
                                w_mplier_nxt = sysbus;
                                w_prod_nxt   = '0;
                                w_cnt_nxt    = SH_W'(WORD_W - 1);
                                w_state_nxt  = S_RUN_MUL;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
            end
            // The zero-count cycle is the extra busy cycle that hands back to IDLE.
            S_RUN_SHR: begin
                if (r_cnt != '0) begin
                    w_acc_nxt = r_acc >> 1;
                    w_c_nxt   = r_acc[0];
                    w_cnt_nxt = r_cnt - SH_W'(1);
                end else begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
`ifdef ALU_MUL_EN
            S_RUN_MUL: begin
                w_prod_nxt   = w_prod_sum;
                w_mcand_nxt  = r_mcand << 1;
                w_mplier_nxt = r_mplier >> 1;
                w_cnt_nxt    = r_cnt - SH_W'(1);
                if (r_cnt == '0) begin
                    w_acc_nxt   = w_prod_sum[MSB:0];
                    w_c_nxt     = |w_prod_sum[2*WORD_W-1:WORD_W];
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.busy   = (r_state != S_IDLE);
    assign bus.done   = r_done;
    assign bus.z_flag = (r_acc == '0);
    assign bus.n_flag = r_acc[MSB];
    assign bus.c_flag = r_c;
    assign bus.v_flag = r_v;

    assign sysbus = bus.ACC_bus ? r_acc : {WORD_W{1'bz}};
endmodule
`default_nettype wire

// File: tb/tb_acc_alu_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_acc_alu_seq
// Brief  : Self-checking bench for acc_alu_seq with a behavioural reference.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_acc_alu_seq;
    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic         clock   = 1'b0;
    logic         n_reset = 1'b0;
    logic [W-1:0] tb_val  = '0;
    wire  [W-1:0] sysbus;

    int checks = 0;
    int errors = 0;
    int nb, nd;

    acc_alu_seq_if #(.OP_W(3)) ifc ();

    acc_alu_seq #(.WORD_W(W), .OP_W(3), .SH_W(3)) dut (
        .clock   (clock),
        .n_reset (n_reset),
        .bus     (ifc.slave),
        .sysbus  (sysbus)
    );

    assign sysbus = ifc.ACC_bus ? {W{1'bz}} : tb_val;

    always #5 clock = ~clock;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference model: arithmetic on integers, multi-cycle ops tracked by cycles left.
    int m_acc = 0, m_c = 0, m_v = 0, m_done = 0, m_left = 0, m_kind = 0;
    int sh_start = 0, sh_n = 0, sh_k = 0, mul_res = 0;
    int md_opnd, md_s, md_dn;

    function automatic int sx(input int a);
        return (a >= (1 << (W-1))) ? a - (1 << W) : a;
    endfunction

    function automatic int ovf(input int s);
        return (s > (1 << (W-1)) - 1 || s < -(1 << (W-1))) ? 1 : 0;
    endfunction

    initial begin
        forever begin
            @(posedge clock or negedge n_reset);
            if (!n_reset) begin
                m_acc = 0; m_c = 0; m_v = 0; m_done = 0; m_left = 0;
            end else begin
                md_opnd = ifc.ACC_bus ? m_acc : int'(tb_val);
                md_dn   = 0;
                if (m_left > 0) begin
                    if (m_kind == 0 && sh_k < sh_n) begin
                        m_acc = sh_start >> (sh_k + 1);
                        m_c   = (sh_start >> sh_k) & 1;
                        sh_k++;
                    end
                    m_left--;
                    if (m_left == 0) begin
                        md_dn = 1;
                        if (m_kind == 1) begin
                            m_acc = mul_res & MASK;
                            m_c   = ((mul_res >> W) != 0) ? 1 : 0;
                        end
                    end
                end else if (ifc.load_ACC) begin
                    if (!ifc.ALU_ACC) begin
                        m_acc = md_opnd;
                    end else begin
                        case (int'(ifc.alu_op))
                            0: begin
                                md_s  = m_acc + md_opnd;
                                m_v   = ovf(sx(m_acc) + sx(md_opnd));
                                m_c   = (md_s > MASK) ? 1 : 0;
                                m_acc = md_s & MASK;
                            end
                            1: begin
                                m_v   = ovf(sx(m_acc) - sx(md_opnd));
                                m_c   = (m_acc < md_opnd) ? 1 : 0;
                                m_acc = (m_acc - md_opnd) & MASK;
                            end
                            2: m_acc = m_acc ^ md_opnd;
                            3: begin
                                m_v   = ovf(sx(m_acc) + 1);
                                m_c   = (m_acc == MASK) ? 1 : 0;
                                m_acc = (m_acc + 1) & MASK;
                            end
                            4: m_acc = m_acc & md_opnd;
                            5: m_acc = m_acc | md_opnd;
                            6: begin
                                m_kind   = 0;
                                sh_start = m_acc;
                                sh_n     = md_opnd % W;
                                sh_k     = 0;
                                m_left   = sh_n + 1;
                            end
                            default: begin
`ifdef ALU_MUL_EN
                                m_kind  = 1;
                                mul_res = m_acc * md_opnd;
                                m_left  = W;
`endif
                            end
                        endcase
                    end
                end
                m_done = md_dn;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (n_reset) begin
                chk("cyc_c",    int'(ifc.c_flag), m_c);
                chk("cyc_v",    int'(ifc.v_flag), m_v);
                chk("cyc_z",    int'(ifc.z_flag), (m_acc == 0) ? 1 : 0);
                chk("cyc_n",    int'(ifc.n_flag), (m_acc >> (W-1)) & 1);
                chk("cyc_busy", int'(ifc.busy),   (m_left > 0) ? 1 : 0);
                chk("cyc_done", int'(ifc.done),   m_done);
                chk("cyc_bus",  int'(sysbus),     ifc.ACC_bus ? m_acc : int'(tb_val));
            end
        end
    end

    task automatic drive(input logic ld, input logic alu, input logic [2:0] op,
                         input logic [W-1:0] val, input logic ab);
        ifc.load_ACC = ld;
        ifc.ALU_ACC  = alu;
        ifc.alu_op   = op;
        tb_val       = val;
        ifc.ACC_bus  = ab;
    endtask

    task automatic op1(input logic alu, input logic [2:0] op, input logic [W-1:0] val,
                       input logic ab);
        @(negedge clock);
        drive(1'b1, alu, op, val, ab);
        @(negedge clock);
        ifc.load_ACC = 1'b0;
        ifc.ACC_bus  = 1'b0;
    endtask

    task automatic peek(input string name, input int exp);
        ifc.ACC_bus = 1'b1;
        #1;
        chk(name, int'(sysbus), exp);
    endtask

    task automatic measure(input bit inject, output int b, output int d);
        b = 0;
        d = 0;
        for (int i = 0; i < 20; i++) begin
            if (ifc.busy) b++;
            if (ifc.done) d++;
            if (inject && i == 1) drive(1'b1, 1'b1, 3'd0, 8'h55, 1'b0);
            else ifc.load_ACC = 1'b0;
            @(negedge clock);
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        repeat (3) @(negedge clock);
        n_reset = 1'b1;
        #1;
        chk("rst_busy", int'(ifc.busy),   0);
        chk("rst_done", int'(ifc.done),   0);
        chk("rst_c",    int'(ifc.c_flag), 0);
        chk("rst_v",    int'(ifc.v_flag), 0);
        chk("rst_z",    int'(ifc.z_flag), 1);
        peek("rst_acc", 'h00);

        op1(1'b0, 3'd0, 8'h7F, 1'b0);
        op1(1'b1, 3'd0, 8'h01, 1'b0);
        peek("add1_acc", 'h80);
        chk("add1_v", int'(ifc.v_flag), 1);
        chk("add1_c", int'(ifc.c_flag), 0);
        chk("add1_n", int'(ifc.n_flag), 1);
        chk("add1_z", int'(ifc.z_flag), 0);
        op1(1'b1, 3'd0, 8'h80, 1'b0);
        peek("add2_acc", 'h00);
        chk("add2_c", int'(ifc.c_flag), 1);
        chk("add2_v", int'(ifc.v_flag), 1);
        chk("add2_z", int'(ifc.z_flag), 1);

        op1(1'b0, 3'd0, 8'h05, 1'b0);
        op1(1'b1, 3'd1, 8'h06, 1'b0);
        peek("sub1_acc", 'hFF);
        chk("sub1_c", int'(ifc.c_flag), 1);
        chk("sub1_v", int'(ifc.v_flag), 0);
        op1(1'b0, 3'd0, 8'h80, 1'b0);
        op1(1'b1, 3'd1, 8'h01, 1'b0);
        peek("sub2_acc", 'h7F);
        chk("sub2_v", int'(ifc.v_flag), 1);
        chk("sub2_c", int'(ifc.c_flag), 0);
        op1(1'b0, 3'd0, 8'hFF, 1'b0);
        op1(1'b1, 3'd3, 8'h00, 1'b0);
        peek("inc_acc", 'h00);
        chk("inc_c", int'(ifc.c_flag), 1);
        chk("inc_z", int'(ifc.z_flag), 1);

        op1(1'b0, 3'd0, 8'hB5, 1'b0);
        op1(1'b1, 3'd6, 8'h03, 1'b0);
        measure(1'b1, nb, nd);
        chk("shr3_busy_cycles", nb, 4);
        chk("shr3_done_pulses", nd, 1);
        peek("shr3_acc", 'h16);
        chk("shr3_c", int'(ifc.c_flag), 1);
        op1(1'b1, 3'd6, 8'h00, 1'b0);
        measure(1'b0, nb, nd);
        chk("shr0_busy_cycles", nb, 1);
        chk("shr0_done_pulses", nd, 1);
        peek("shr0_acc", 'h16);
        chk("shr0_c", int'(ifc.c_flag), 1);

`ifdef ALU_MUL_EN
        op1(1'b0, 3'd0, 8'h12, 1'b0);
        op1(1'b1, 3'd7, 8'h10, 1'b0);
        measure(1'b0, nb, nd);
        chk("mul1_busy_cycles", nb, 8);
        chk("mul1_done_pulses", nd, 1);
        peek("mul1_acc", 'h20);
        chk("mul1_c", int'(ifc.c_flag), 1);
        op1(1'b0, 3'd0, 8'h0F, 1'b0);
        op1(1'b1, 3'd7, 8'h03, 1'b0);
        measure(1'b0, nb, nd);
        chk("mul2_busy_cycles", nb, 8);
        peek("mul2_acc", 'h2D);
        chk("mul2_c", int'(ifc.c_flag), 0);
`else
        op1(1'b0, 3'd0, 8'h12, 1'b0);
        op1(1'b1, 3'd7, 8'h10, 1'b0);
        measure(1'b0, nb, nd);
        chk("op7_busy_cycles", nb, 0);
        chk("op7_done_pulses", nd, 0);
        peek("op7_acc", 'h12);
`endif

        op1(1'b0, 3'd0, 8'hFF, 1'b0);
        peek("drive_acc", 'hFF);
        @(negedge clock);
        ifc.ACC_bus = 1'b0;
        tb_val      = 8'h00;
        #1;
        chk("release_bus", int'(sysbus), 'h00);
        op1(1'b1, 3'd2, 8'h00, 1'b1);
        chk("xor_self_z", int'(ifc.z_flag), 1);
        peek("xor_self_acc", 'h00);

        op1(1'b0, 3'd0, 8'h7F, 1'b0);
        op1(1'b1, 3'd0, 8'h01, 1'b0);
        op1(1'b0, 3'd0, 8'hF0, 1'b0);
        op1(1'b1, 3'd6, 8'h05, 1'b0);
        repeat (2) @(posedge clock);
        #2;
        chk("rstmid_pre_busy", int'(ifc.busy), 1);
        chk("rstmid_pre_v",    int'(ifc.v_flag), 1);
        n_reset = 1'b0;
        #1;
        chk("rstmid_busy", int'(ifc.busy),   0);
        chk("rstmid_done", int'(ifc.done),   0);
        chk("rstmid_c",    int'(ifc.c_flag), 0);
        chk("rstmid_v",    int'(ifc.v_flag), 0);
        chk("rstmid_z",    int'(ifc.z_flag), 1);
        @(negedge clock);
        n_reset = 1'b1;

        repeat (600) begin
            @(negedge clock);
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                  3'($urandom_range(0, 7)), 8'($urandom), ($urandom_range(0, 3) == 0));
        end
        @(negedge clock);
        drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        repeat (12) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
